gbe_rx_status_gen: RTL and testbench
====================================

GBE_RX_STATUS_GEN -- requirements
Module: gbe_rx_status_gen

Interface
REQ-001 SHALL have parameter MAX_FRAME_BEATS, default 1125; maximum legal 64-bit beats per frame (9000 B jumbo).
REQ-002 SHALL have port user_clk, input, 1; the only clock.
REQ-003 SHALL have port user_rst, input, 1; reset, synchronous and active-high.
REQ-004 SHALL have port rx_valid, input, 1; receive data beat present this cycle.
REQ-005 SHALL have port rx_eof, input, 1; last beat of a frame, qualified by rx_valid.
REQ-006 SHALL have port rx_bad_frame, input, 1; CRC/MAC error flag, qualified by rx_valid & rx_eof.
REQ-007 SHALL have port rx_overrun, input, 1; RX FIFO overrun strobe, unqualified.
REQ-008 SHALL have port rx_linkup, input, 1; PHY link status level.
REQ-009 SHALL have port clr, input, 1; software counter clear, level from a control register.
REQ-010 SHALL have port status_word, output, 32; word driven into the 32-bit user_data_in of the software-readable status register.
REQ-011 SHALL have port frame_done, output, 1; one-cycle pulse per completed frame, good or bad.

Function
REQ-012 SHALL map status_word fields: [31] link_up, [30] overrun_sticky, [29] bad_sticky, [28] oversize_sticky, [27:26] FSM state, [25:16] bad_cnt, [15:0] good_cnt.
REQ-013 SHALL register every status_word field; each field reflects its input event one cycle after the event cycle.
REQ-014 SHALL implement FSM states IDLE=00, IN_FRAME=01, DROP=10; encoding 11 is unreachable and SHALL recover to IDLE.
REQ-015 SHALL transition IDLE->IN_FRAME on rx_valid & ~rx_eof; rx_valid & rx_eof in IDLE is a single-beat frame that completes and stays in IDLE.
REQ-016 SHALL transition IN_FRAME->IDLE on rx_valid & rx_eof and complete the frame.
REQ-017 SHALL transition IN_FRAME->DROP on rx_overrun when no rx_eof occurs in the same cycle.
REQ-018 SHALL transition DROP->IDLE on rx_valid & rx_eof; a frame ending from DROP is counted bad regardless of rx_bad_frame.
REQ-019 SHALL count a completed frame as good (good_cnt+1) only when rx_bad_frame=0 and it did not pass through DROP; otherwise it SHALL increment bad_cnt and set bad_sticky.
REQ-020 SHALL let good_cnt wrap modulo 2^16 and SHALL saturate bad_cnt at 1023.
REQ-021 SHALL set overrun_sticky on any rx_overrun in any state; rx_overrun in IDLE SHALL NOT change state or counters.
REQ-022 SHALL detect a clr rising edge using a registered copy of clr; the edge SHALL zero both counters and all sticky bits, and holding clr high SHALL NOT clear again.
REQ-023 SHALL apply a clr edge first when it coincides with a frame completion, then count that frame (resulting count = 1).
REQ-024 SHALL assert frame_done in the cycle after the completing beat.
REQ-025 SHALL take link_up as rx_linkup delayed by one register, with no stickiness.

Reset
REQ-026 SHALL, while user_rst=1, force the FSM to IDLE, status_word to 0x00000000, frame_done to 0, the beat counter to 0, and the clr edge register to 0.
REQ-027 SHALL abandon a frame in progress at reset without counting it; the first rx_eof after reset while in IDLE SHALL be treated as a single-beat frame.

Configuration
REQ-028 SHALL, when macro GBE_RX_STATUS_OVERSIZE_EN is defined, count beats in IN_FRAME and enter DROP and set oversize_sticky when a beat with ~rx_eof arrives as beat number MAX_FRAME_BEATS.
REQ-029 SHALL, when GBE_RX_STATUS_OVERSIZE_EN is undefined, omit the beat counter, tie oversize_sticky to 0, and never size-limit frames.

Structure
REQ-030 SHALL place the FSM state enum, field bit positions, and counter widths (16, 10) in package gbe_rx_status_pkg.
REQ-031 SHALL implement the saturating/wrapping counter with clear as sub-module gbe_rx_status_cnt, instanced twice.

Verification
REQ-032 SHALL cover: 3 good 4-beat frames -> good_cnt=3, bad_cnt=0, frame_done pulsed 3 times, status_word=0x80000003 with link up.
REQ-033 SHALL cover: frame with rx_bad_frame=1 at eof -> bad_cnt=1, bad_sticky=1, good_cnt unchanged.
REQ-034 SHALL cover: rx_overrun at beat 2 of a 5-beat frame -> state=DROP until eof, then bad_cnt+1 and overrun_sticky=1.
REQ-035 SHALL cover: 1030 bad frames -> bad_cnt=1023; then 65537 good frames -> good_cnt=1.
REQ-036 SHALL cover: clr held high for 10 cycles with a completion on the edge cycle -> good_cnt=1, stickies 0, no further clears.
REQ-037 SHALL cover: with GBE_RX_STATUS_OVERSIZE_EN defined and MAX_FRAME_BEATS=8, a 12-beat frame -> oversize_sticky=1, bad_cnt=1; user_rst mid-frame -> status_word=0.

Source files
------------

// File: rtl/gbe_rx_status_pkg.sv
// gbe_rx_status_pkg: RX status FSM encoding, status word field layout and counter widths
package gbe_rx_status_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, IN_FRAME = 2'b01, DROP = 2'b10} state_t;
  localparam int GOOD_W = 16;
  localparam int BAD_W = 10;
  localparam int LINK_BIT = 31;
  localparam int OVR_BIT = 30;
  localparam int BAD_BIT = 29;
  localparam int OVS_BIT = 28;
  localparam int STATE_LSB = 26;
  localparam int BAD_LSB = 16;
  localparam int GOOD_LSB = 0;
endpackage

// File: rtl/gbe_rx_status_cnt.sv
// gbe_rx_status_cnt: event counter where a clear and an increment in one cycle give 1
module gbe_rx_status_cnt #(
  parameter int W = 16,
  parameter bit SAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] base;
  always_comb base = clr ? '0 : cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (inc && !(SAT && &base)) cnt <= base + W'(1);
    else cnt <= base;
endmodule

// File: rtl/gbe_rx_status_gen.sv
// gbe_rx_status_gen: RX frame FSM producing good/bad counters, sticky flags and link in a status word.
// Define GBE_RX_STATUS_OVERSIZE_EN to drop frames reaching MAX_FRAME_BEATS beats.
module gbe_rx_status_gen
  import gbe_rx_status_pkg::*;
#(
  parameter int MAX_FRAME_BEATS = 1125
) (
  input  logic        user_clk,
  input  logic        user_rst,
  input  logic        rx_valid,
  input  logic        rx_eof,
  input  logic        rx_bad_frame,
  input  logic        rx_overrun,
  input  logic        rx_linkup,
  input  logic        clr,
  output logic [31:0] status_word,
  output logic        frame_done
);
  state_t state, state_next;
  logic clr_q, clr_edge, link_q, ovr_sticky, bad_sticky, oversize, oversize_sticky, done, bad;
  logic [GOOD_W-1:0] good_cnt;
  logic [BAD_W-1:0] bad_cnt;
  assign clr_edge = clr & ~clr_q;
  always_comb begin
    state_next = state;
    done = 1'b0;
    bad = 1'b0;
    case (state)
      IDLE: begin
        done = rx_valid & rx_eof;
        bad = rx_bad_frame;
        state_next = (rx_valid & ~rx_eof) ? IN_FRAME : IDLE;
      end
      IN_FRAME: begin
        done = rx_valid & rx_eof;
        bad = rx_bad_frame;
        state_next = done ? IDLE : (rx_overrun | oversize) ? DROP : IN_FRAME;
      end
      DROP: begin
        done = rx_valid & rx_eof;
        bad = 1'b1;
        state_next = done ? IDLE : DROP;
      end
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge user_clk)
    if (user_rst) begin
      state <= IDLE;
      clr_q <= 1'b0;
      link_q <= 1'b0;
      ovr_sticky <= 1'b0;
      bad_sticky <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_next;
      clr_q <= clr;
      link_q <= rx_linkup;
      ovr_sticky <= (ovr_sticky & ~clr_edge) | rx_overrun;
      bad_sticky <= (bad_sticky & ~clr_edge) | (done & bad);
      frame_done <= done;
    end
  gbe_rx_status_cnt #(.W(GOOD_W), .SAT(1'b0)) u_good (
    .clk(user_clk), .rst(user_rst), .clr(clr_edge), .inc(done & ~bad), .cnt(good_cnt)
  );
  gbe_rx_status_cnt #(.W(BAD_W), .SAT(1'b1)) u_bad (
    .clk(user_clk), .rst(user_rst), .clr(clr_edge), .inc(done & bad), .cnt(bad_cnt)
  );
`ifdef GBE_RX_STATUS_OVERSIZE_EN
  localparam int BW = $clog2(MAX_FRAME_BEATS + 1);
  logic [BW-1:0] beat_cnt;
  // beat_cnt holds beats already accepted, so the incoming one is beat_cnt+1
  assign oversize = state == IN_FRAME && rx_valid && !rx_eof && beat_cnt == BW'(MAX_FRAME_BEATS - 1);
  always_ff @(posedge user_clk)
    if (user_rst) begin
      beat_cnt <= '0;
      oversize_sticky <= 1'b0;
    end else begin
      beat_cnt <= state_next != IN_FRAME ? '0 : state == IN_FRAME ? beat_cnt + BW'(rx_valid) : BW'(1);
      oversize_sticky <= (oversize_sticky & ~clr_edge) | oversize;
    end
`else
  logic unused_max;
  assign unused_max = ^MAX_FRAME_BEATS;
  assign oversize = 1'b0;
  assign oversize_sticky = 1'b0;
`endif
  always_comb begin
    status_word = '0;
    status_word[LINK_BIT] = link_q;
    status_word[OVR_BIT] = ovr_sticky;
    status_word[BAD_BIT] = bad_sticky;
    status_word[OVS_BIT] = oversize_sticky;
    status_word[STATE_LSB +: 2] = state;
    status_word[BAD_LSB +: BAD_W] = bad_cnt;
    status_word[GOOD_LSB +: GOOD_W] = good_cnt;
  end
endmodule

// File: tb/tb_gbe_rx_status_gen.sv
// tb_gbe_rx_status_gen: directed and randomized checks against a frame-level reference model
module tb_gbe_rx_status_gen;
  localparam int MAXB = 8;
`ifdef GBE_RX_STATUS_OVERSIZE_EN
  localparam bit OVS_EN = 1'b1;
`else
  localparam bit OVS_EN = 1'b0;
`endif
  logic user_clk = 1'b0, user_rst = 1'b1;
  logic rx_valid = 1'b0, rx_eof = 1'b0, rx_bad_frame = 1'b0, rx_overrun = 1'b0;
  logic rx_linkup = 1'b0, clr = 1'b0;
  logic [31:0] status_word;
  logic frame_done;
  int checks = 0, failures = 0;
  int m_good, m_bad, m_beats;
  bit m_in, m_drop, m_ovr, m_bads, m_ovs, m_done, m_link, m_clrq;

  gbe_rx_status_gen #(.MAX_FRAME_BEATS(MAXB)) dut (
    .user_clk(user_clk), .user_rst(user_rst), .rx_valid(rx_valid), .rx_eof(rx_eof),
    .rx_bad_frame(rx_bad_frame), .rx_overrun(rx_overrun), .rx_linkup(rx_linkup),
    .clr(clr), .status_word(status_word), .frame_done(frame_done)
  );

  always #5 user_clk = ~user_clk;

  function automatic logic [31:0] exp_sw();
    logic [1:0] st;
    st = !m_in ? 2'd0 : m_drop ? 2'd2 : 2'd1;
    return {m_link, m_ovr, m_bads, m_ovs, st, 10'(m_bad), 16'(m_good)};
  endfunction

  // Drives one beat and advances the frame-level model by the same cycle.
  task automatic cyc(input bit v, input bit e, input bit b, input bit o);
    bit ce, ovs;
    rx_valid = v; rx_eof = e; rx_bad_frame = b; rx_overrun = o;
    if (user_rst) begin
      m_good = 0; m_bad = 0; m_beats = 0; m_in = 0; m_drop = 0; m_ovr = 0;
      m_bads = 0; m_ovs = 0; m_done = 0; m_link = 0; m_clrq = 0;
    end else begin
      ce = clr && !m_clrq;
      m_clrq = clr;
      m_link = rx_linkup;
      m_done = v && e;
      if (ce) begin m_good = 0; m_bad = 0; m_ovr = 0; m_bads = 0; m_ovs = 0; end
      ovs = OVS_EN && m_in && !m_drop && v && !e && (m_beats + 1 == MAXB);
      if (v && e) begin
        if (m_drop || b) begin m_bad = (m_bad >= 1023) ? 1023 : m_bad + 1; m_bads = 1; end
        else m_good = (m_good + 1) % 65536;
        m_in = 0; m_drop = 0; m_beats = 0;
      end else if (v && !m_in) begin m_in = 1; m_beats = 1; end
      else if (m_in && !m_drop && (o || ovs)) m_drop = 1;
      else if (m_in && !m_drop && v) m_beats++;
      if (ovs) m_ovs = 1;
      if (o) m_ovr = 1;
    end
    @(posedge user_clk);
    #1;
  endtask

  task automatic test_reset();
    user_rst = 1; clr = 1; rx_linkup = 1;
    repeat (3) cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    checks++;
    if (status_word !== 32'h0) begin failures++; $display("FAIL reset_status: got %h want 00000000", status_word); end
    checks++;
    if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", frame_done); end
    user_rst = 0; clr = 0;
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_good_frames();
    int n = 0;
    rx_linkup = 1;
    cyc(0, 0, 0, 0);
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 4; i++) begin
        cyc(1, i == 3, 0, 0);
        n += int'(frame_done);
        checks++;
        if (frame_done !== m_done) begin failures++; $display("FAIL good_done: got %b want %b", frame_done, m_done); end
      end
    cyc(0, 0, 0, 0);
    n += int'(frame_done);
    checks++;
    if (n != 3) begin failures++; $display("FAIL good_pulses: got %0d want 3", n); end
    checks++;
    if (status_word !== 32'h80000003) begin failures++; $display("FAIL good_status: got %h want 80000003", status_word); end
  endtask

  task automatic test_bad_frame();
    cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 0);
    checks++;
    if (status_word[25:16] !== 10'd1) begin failures++; $display("FAIL bad_cnt: got %0d want 1", status_word[25:16]); end
    checks++;
    if (status_word[29] !== 1'b1) begin failures++; $display("FAIL bad_sticky: got %b want 1", status_word[29]); end
    checks++;
    if (status_word[15:0] !== 16'd3) begin failures++; $display("FAIL bad_good_cnt: got %0d want 3", status_word[15:0]); end
  endtask

  task automatic test_overrun_drop();
    for (int i = 1; i <= 5; i++) begin
      cyc(1, i == 5, 0, i == 2);
      if (i >= 2 && i <= 4) begin
        checks++;
        if (status_word[27:26] !== 2'd2) begin failures++; $display("FAIL drop_state: got %0d want 2", status_word[27:26]); end
      end
    end
    checks++;
    if (status_word !== 32'hE0020003) begin failures++; $display("FAIL drop_status: got %h want e0020003", status_word); end
  endtask

  task automatic test_clr_hold();
    clr = 1;
    cyc(1, 1, 0, 0);
    checks++;
    if (status_word !== 32'h80000001) begin failures++; $display("FAIL clr_edge: got %h want 80000001", status_word); end
    cyc(0, 0, 0, 1);
    cyc(1, 1, 1, 0);
    cyc(1, 1, 0, 0);
    repeat (6) cyc(0, 0, 0, 0);
    checks++;
    if (status_word !== 32'hE0010002) begin failures++; $display("FAIL clr_hold: got %h want e0010002", status_word); end
    clr = 0;
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_oversize();
    for (int i = 1; i <= 12; i++) cyc(1, i == 12, 0, 0);
    checks++;
    if (status_word !== exp_sw()) begin failures++; $display("FAIL oversize_status: got %h want %h", status_word, exp_sw()); end
    checks++;
    if (status_word[28] !== OVS_EN) begin failures++; $display("FAIL oversize_sticky: got %b want %b", status_word[28], OVS_EN); end
    checks++;
    if (status_word[25:16] !== (OVS_EN ? 10'd2 : 10'd1)) begin
      failures++; $display("FAIL oversize_bad: got %0d want %0d", status_word[25:16], OVS_EN ? 2 : 1);
    end
  endtask

  task automatic test_reset_midframe();
    repeat (3) cyc(1, 0, 0, 0);
    user_rst = 1;
    cyc(1, 0, 0, 0);
    checks++;
    if (status_word !== 32'h0) begin failures++; $display("FAIL midrst_status: got %h want 00000000", status_word); end
    user_rst = 0;
    cyc(1, 1, 0, 0);
    checks++;
    if (status_word !== 32'h80000001) begin failures++; $display("FAIL midrst_single: got %h want 80000001", status_word); end
    checks++;
    if (frame_done !== 1'b1) begin failures++; $display("FAIL midrst_done: got %b want 1", frame_done); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(49) == 0) clr = ~clr;
      if ($urandom_range(19) == 0) rx_linkup = ~rx_linkup;
      cyc($urandom_range(3) != 0, $urandom_range(4) == 0, $urandom_range(5) == 0, $urandom_range(24) == 0);
      checks++;
      if (status_word !== exp_sw()) begin failures++; $display("FAIL rand_status[%0d]: got %h want %h", i, status_word, exp_sw()); end
      checks++;
      if (frame_done !== m_done) begin failures++; $display("FAIL rand_done[%0d]: got %b want %b", i, frame_done, m_done); end
    end
    clr = 0;
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_saturation();
    clr = 1;
    cyc(0, 0, 0, 0);
    clr = 0;
    cyc(0, 0, 0, 0);
    repeat (1030) cyc(1, 1, 1, 0);
    checks++;
    if (status_word[25:16] !== 10'd1023) begin failures++; $display("FAIL sat_bad: got %0d want 1023", status_word[25:16]); end
    repeat (65537) cyc(1, 1, 0, 0);
    checks++;
    if (status_word[15:0] !== 16'd1) begin failures++; $display("FAIL wrap_good: got %0d want 1", status_word[15:0]); end
    checks++;
    if (status_word !== exp_sw()) begin failures++; $display("FAIL wrap_status: got %h want %h", status_word, exp_sw()); end
  endtask

  initial begin
    test_reset();
    test_good_frames();
    test_bad_frame();
    test_overrun_drop();
    test_clr_hold();
    test_oversize();
    test_reset_midframe();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
